// File: rtl/keypad_pkg.sv
// Shared constants and types for the TTP229 keypad scan controller.
package keypad_pkg;

  localparam int unsigned NUM_KEYS  = 16;
  localparam int unsigned KEY_IDX_W = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitFrame,
    StEmit,
    StGap
  } scan_state_e;

  typedef struct packed {
    logic [KEY_IDX_W-1:0] key;
    logic                 press;
    logic                 rpt;
  } key_event_t;

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Key event stream: valid/ready handshake carrying one press/release/repeat event.
interface keypad_scan_ctrl_if;

  logic                            ev_valid;
  logic                            ev_ready;
  logic [keypad_pkg::KEY_IDX_W-1:0] ev_key;
  logic                            ev_press;
  logic                            ev_repeat;

  modport master (
    output ev_valid,
    output ev_key,
    output ev_press,
    output ev_repeat,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_key,
    input  ev_press,
    input  ev_repeat,
    output ev_ready
  );

endinterface

// File: rtl/key_event_fifo.sv
// Synchronous event FIFO; a push into a full FIFO succeeds only alongside a pop.
module key_event_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       push_i,
  input  key_event_t ev_i,
  input  logic       pop_i,
  output key_event_t ev_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  key_event_t      mem_q [DEPTH];
  logic [PtrW:0]   wr_q, wr_d;
  logic [PtrW:0]   rd_q, rd_d;
  logic [PtrW-1:0] wr_addr, rd_addr;
  logic            do_push, do_pop;

  assign wr_addr = wr_q[PtrW-1:0];
  assign rd_addr = rd_q[PtrW-1:0];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PtrW] != rd_q[PtrW]) && (wr_addr == rd_addr);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  // Head is forced to zero when empty so the outputs read clean after reset.
  assign ev_o    = empty_o ? '0 : mem_q[rd_addr];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (PtrW + 1)'(1);
    if (do_pop)  rd_d = rd_q + (PtrW + 1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_addr] <= ev_i;
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Periodic TTP229 scan sequencer with frame debounce and a press/release event FIFO.
// Auto-repeat events are built only when KEY_REPEAT_EN is defined.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_GAP_CYC      = 24000,
  parameter int unsigned FRAME_TIMEOUT_CYC = 480000,
  parameter int unsigned DEB_FRAMES        = 3,
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned REPEAT_FRAMES     = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  output logic                scan_start,
  input  logic                frame_valid,
  input  logic [NUM_KEYS-1:0] frame_data,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                nokey,
  keypad_scan_ctrl_if.master  ev,
  output logic                ev_overflow,
  output logic                timeout_err,
  input  logic                clear_err
);

  localparam int unsigned ToW  = (FRAME_TIMEOUT_CYC > 1) ? $clog2(FRAME_TIMEOUT_CYC) : 1;
  localparam int unsigned GapW = (SCAN_GAP_CYC > 1) ? $clog2(SCAN_GAP_CYC) : 1;
  localparam logic [ToW-1:0]       ToLast  = ToW'(FRAME_TIMEOUT_CYC - 1);
  localparam logic [GapW-1:0]      GapLast = GapW'(SCAN_GAP_CYC - 1);
  localparam logic [2:0]           DebMax  = 3'(DEB_FRAMES);
  localparam logic [KEY_IDX_W-1:0] IdxLast = KEY_IDX_W'(NUM_KEYS - 1);

  if (DEB_FRAMES < 1 || DEB_FRAMES > 7) begin : g_bad_deb
    $error("DEB_FRAMES must be in 1..7");
  end
  if (REPEAT_FRAMES < 1) begin : g_bad_rpt
    $error("REPEAT_FRAMES must be at least 1");
  end

  scan_state_e          state_q, state_d;
  logic [ToW-1:0]       to_cnt_q, to_cnt_d;
  logic [GapW-1:0]      gap_cnt_q, gap_cnt_d;
  logic [KEY_IDX_W-1:0] idx_q, idx_d;
  logic [NUM_KEYS-1:0]  key_state_q, key_state_d;
  logic [NUM_KEYS-1:0]  cand_q, cand_d;
  logic [NUM_KEYS-1:0]  diff_q, diff_d;
  logic [2:0]           match_q, match_d;
  logic                 ovf_q, ovf_d;
  logic                 to_err_q, to_err_d;
  logic                 deb_edge, accept, set_to, push, drop;
  key_event_t           push_ev, head_ev;
  logic                 fifo_full, fifo_empty;

`ifdef KEY_REPEAT_EN
  localparam int unsigned RptW = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
  localparam logic [RptW-1:0] RptLast = RptW'(REPEAT_FRAMES - 1);
  logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic            rpt_pend_q, rpt_pend_d;
`endif

  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    idx_d       = idx_q;
    key_state_d = key_state_q;
    cand_d      = cand_q;
    match_d     = match_q;
    diff_d      = diff_q;
    deb_edge    = 1'b0;
    accept      = 1'b0;
    set_to      = 1'b0;
    push        = 1'b0;
    push_ev     = '0;
    scan_start  = 1'b0;
`ifdef KEY_REPEAT_EN
    rpt_cnt_d   = rpt_cnt_q;
    rpt_pend_d  = rpt_pend_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StStart;
      end
      StStart: begin
        scan_start = 1'b1;
        to_cnt_d   = '0;
        state_d    = StWaitFrame;
      end
      StWaitFrame: begin
        if (frame_valid) begin
          // Acceptance fires only on the cycle the match count reaches DEB_FRAMES.
          if (frame_data == cand_q) begin
            deb_edge = (match_q == DebMax - 3'd1);
            if (match_q != DebMax) match_d = match_q + 3'd1;
          end else begin
            deb_edge = (DebMax == 3'd1);
            cand_d   = frame_data;
            match_d  = 3'd1;
          end
          accept = deb_edge && (frame_data != key_state_q);
          diff_d = accept ? (frame_data ^ key_state_q) : '0;
          if (accept) key_state_d = frame_data;
`ifdef KEY_REPEAT_EN
          rpt_pend_d = 1'b0;
          if (accept || !$onehot(key_state_q)) begin
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q == RptLast) begin
            rpt_cnt_d  = '0;
            rpt_pend_d = 1'b1;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RptW'(1);
          end
`endif
          idx_d   = '0;
          state_d = StEmit;
        end else if (to_cnt_q == ToLast) begin
          set_to    = 1'b1;
          gap_cnt_d = '0;
          state_d   = StGap;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      StEmit: begin
        push_ev.key   = idx_q;
        push_ev.press = key_state_q[idx_q];
        push          = diff_q[idx_q];
`ifdef KEY_REPEAT_EN
        if (rpt_pend_q && key_state_q[idx_q] && !diff_q[idx_q]) begin
          push          = 1'b1;
          push_ev.press = 1'b1;
          push_ev.rpt   = 1'b1;
        end
`endif
        if (idx_q == IdxLast) begin
          gap_cnt_d = '0;
          state_d   = StGap;
        end else begin
          idx_d = idx_q + KEY_IDX_W'(1);
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = enable ? StStart : StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A push is lost only when the FIFO is full and the head is not leaving this cycle.
  assign drop     = push & fifo_full & ~(ev.ev_ready & ~fifo_empty);
  assign ovf_d    = drop | (ovf_q & ~clear_err);
  assign to_err_d = set_to | (to_err_q & ~clear_err);

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q     <= StIdle;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      idx_q       <= '0;
      key_state_q <= '0;
      cand_q      <= '0;
      diff_q      <= '0;
      match_q     <= '0;
      ovf_q       <= 1'b0;
      to_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      idx_q       <= idx_d;
      key_state_q <= key_state_d;
      cand_q      <= cand_d;
      diff_q      <= diff_d;
      match_q     <= match_d;
      ovf_q       <= ovf_d;
      to_err_q    <= to_err_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk) begin
    if (reset_n) begin
      rpt_cnt_q  <= '0;
      rpt_pend_q <= 1'b0;
    end else begin
      rpt_cnt_q  <= rpt_cnt_d;
      rpt_pend_q <= rpt_pend_d;
    end
  end
`endif

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset_n),
    .push_i  (push),
    .ev_i    (push_ev),
    .pop_i   (ev.ev_ready),
    .ev_o    (head_ev),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign key_state    = key_state_q;
  assign nokey        = ~|key_state_q;
  assign ev_overflow  = ovf_q;
  assign timeout_err  = to_err_q;
  assign ev.ev_valid  = ~fifo_empty;
  assign ev.ev_key    = head_ev.key;
  assign ev.ev_press  = head_ev.press;
`ifdef KEY_REPEAT_EN
  assign ev.ev_repeat = head_ev.rpt;
`else
  assign ev.ev_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: reader stub, debounce/event model and event scoreboard.
module tb_keypad_scan_ctrl;
  import keypad_pkg::*;

  localparam int unsigned GAP   = 8;
  localparam int unsigned TO    = 40;
  localparam int unsigned DEB   = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RPT   = 4;

  logic        clk         = 1'b0;
  logic        reset_n     = 1'b1;
  logic        enable      = 1'b0;
  logic        frame_valid = 1'b0;
  logic        clear_err   = 1'b0;
  logic [15:0] frame_data  = '0;
  logic        scan_start, nokey, ev_overflow, timeout_err;
  logic [15:0] key_state;

  keypad_scan_ctrl_if ev ();

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int scan_cyc = 0;

  key_event_t  exp_q[$];
  logic [15:0] m_ks  = '0;
  logic [15:0] m_run = '0;
  int          m_len = 0;
  int          m_rpt = 0;
  logic        m_ovf = 1'b0;

  keypad_scan_ctrl #(
    .SCAN_GAP_CYC      (GAP),
    .FRAME_TIMEOUT_CYC (TO),
    .DEB_FRAMES        (DEB),
    .FIFO_DEPTH        (DEPTH),
    .REPEAT_FRAMES     (RPT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .scan_start  (scan_start),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .key_state   (key_state),
    .nokey       (nokey),
    .ev          (ev),
    .ev_overflow (ev_overflow),
    .timeout_err (timeout_err),
    .clear_err   (clear_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drop rule assumes the consumer is stalled, so the queue length equals FIFO occupancy.
  task automatic exp_push(input int k, input logic p, input logic r);
    key_event_t e;
    e.key   = 4'(k);
    e.press = p;
    e.rpt   = r;
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else m_ovf = 1'b1;
  endtask

  task automatic model_frame(input logic [15:0] d);
    logic acc;
    if (d == m_run) m_len++;
    else begin
      m_run = d;
      m_len = 1;
    end
    acc = (m_len == DEB) && (m_run != m_ks);
    if (acc) begin
      for (int i = 0; i < 16; i++)
        if (d[i] != m_ks[i]) exp_push(i, d[i], 1'b0);
      m_ks = d;
    end
`ifdef KEY_REPEAT_EN
    if (acc || $countones(m_ks) != 1) m_rpt = 0;
    else begin
      m_rpt++;
      if (m_rpt == RPT) begin
        m_rpt = 0;
        for (int i = 0; i < 16; i++)
          if (m_ks[i]) exp_push(i, 1'b1, 1'b1);
      end
    end
`endif
  endtask

  task automatic wait_scan();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (scan_start !== 1'b1 && n < 200);
    if (scan_start !== 1'b1) check("scan_start_wait", 32'(scan_start), 32'd1);
    scan_cyc = cyc;
  endtask

  // Answer the next scan request with a frame two cycles after scan_start.
  task automatic do_frame(input logic [15:0] d);
    wait_scan();
    step(2);
    frame_valid = 1'b1;
    frame_data  = d;
    model_frame(d);
    step(1);
    frame_valid = 1'b0;
    @(negedge clk);
    check("key_state", 32'(key_state), 32'(m_ks));
    check("nokey", 32'(nokey), 32'(m_ks == 16'h0));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    key_event_t e;
    if (reset_n === 1'b0 && ev.ev_valid === 1'b1 && ev.ev_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("ev_unexpected", 32'(ev.ev_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("ev_key", 32'(ev.ev_key), 32'(e.key));
        check("ev_press", 32'(ev.ev_press), 32'(e.press));
        check("ev_repeat", 32'(ev.ev_repeat), 32'(e.rpt));
      end
    end
  end

  initial begin
    int t0;
    int sa;
    int n;
    int pulses;

    ev.ev_ready = 1'b0;
    step(3);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_scan_start", 32'(scan_start), 32'd0);
    check("rst_key_state", 32'(key_state), 32'd0);
    check("rst_nokey", 32'(nokey), 32'd1);
    check("rst_ev_valid", 32'(ev.ev_valid), 32'd0);
    check("rst_ev_key", 32'(ev.ev_key), 32'd0);
    check("rst_ev_repeat", 32'(ev.ev_repeat), 32'd0);
    check("rst_overflow", 32'(ev_overflow), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);

    step(1);
    enable      = 1'b1;
    ev.ev_ready = 1'b1;

    // Basic press then release of key 0.
    repeat (3) do_frame(16'h0001);
    repeat (3) do_frame(16'h0000);
    drain();

    // A glitch frame restarts the debounce run.
    do_frame(16'h0010);
    do_frame(16'h0000);
    do_frame(16'h0010);
    do_frame(16'h0010);
    check("glitch_hold", 32'(key_state), 32'h0);
    do_frame(16'h0010);
    check("glitch_accept", 32'(key_state), 32'h10);
    repeat (3) do_frame(16'h0000);
    drain();

    // Stalled consumer: three presses fit, the release burst overflows.
    ev.ev_ready = 1'b0;
    repeat (3) do_frame(16'h8003);
    step(18);
    @(negedge clk);
    check("ovf_head_valid", 32'(ev.ev_valid), 32'd1);
    check("ovf_head_key", 32'(ev.ev_key), 32'd0);
    check("ovf_head_press", 32'(ev.ev_press), 32'd1);
    check("ovf_before", 32'(ev_overflow), 32'(m_ovf));
    repeat (3) do_frame(16'h0000);
    step(18);
    @(negedge clk);
    check("ovf_after", 32'(ev_overflow), 32'(m_ovf));
    check("ovf_head_stable", 32'(ev.ev_key), 32'd0);
    step(1);
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
    m_ovf     = 1'b0;
    @(negedge clk);
    check("ovf_cleared", 32'(ev_overflow), 32'd0);
    ev.ev_ready = 1'b1;
    drain();

    // Missing frame: timeout, gap, then a new request; then a normal scan period.
    do_frame(16'h0000);
    step(1);
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
    @(negedge clk);
    check("to_cleared", 32'(timeout_err), 32'd0);
    wait_scan();
    t0 = scan_cyc;
    n  = 0;
    while (timeout_err !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("to_latency", 32'(cyc - t0), 32'(TO + 1));
    wait_scan();
    check("to_period", 32'(scan_cyc - t0), 32'(1 + TO + GAP));
    do_frame(16'h0000);
    sa = scan_cyc;
    do_frame(16'h0000);
    check("scan_period", 32'(scan_cyc - sa), 32'(1 + 2 + 16 + GAP));

    // Reset in the middle of EMIT with two events already queued.
    ev.ev_ready = 1'b0;
    repeat (3) do_frame(16'h0003);
    step(2);
    @(negedge clk);
    check("mid_emit_valid", 32'(ev.ev_valid), 32'd1);
    step(1);
    reset_n = 1'b1;
    enable  = 1'b0;
    step(1);
    reset_n = 1'b0;
    exp_q.delete();
    m_ks  = '0;
    m_run = '0;
    m_len = 0;
    m_rpt = 0;
    m_ovf = 1'b0;
    @(negedge clk);
    check("mrst_ev_valid", 32'(ev.ev_valid), 32'd0);
    check("mrst_key_state", 32'(key_state), 32'd0);
    check("mrst_nokey", 32'(nokey), 32'd1);
    check("mrst_scan_start", 32'(scan_start), 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (scan_start === 1'b1) pulses++;
    end
    check("mrst_idle_pulses", 32'(pulses), 32'd0);
    step(1);
    enable      = 1'b1;
    ev.ev_ready = 1'b1;
    repeat (3) do_frame(16'h0001);
    drain();

`ifdef KEY_REPEAT_EN
    // Key 5 held repeats every RPT frames; a second key stops repeats.
    repeat (3) do_frame(16'h0020);
    repeat (8) do_frame(16'h0020);
    repeat (3) do_frame(16'h0021);
    repeat (5) do_frame(16'h0021);
    repeat (3) do_frame(16'h0000);
    drain();
`endif

    step(20);
    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequences the 16-key TTP229 two-wire serial reader. Issues one scan request per frame, paces frames with a programmable gap, and watches for a missing frame with a timeout.
- Debounces the returned 16-bit frames and turns debounced changes into press/release events, serialized one per cycle.
- Events are buffered in a small FIFO with a valid/ready consumer handshake. The downstream consumer is the encoder/segment display path or a CPU.

Parameters:
- SCAN_GAP_CYC, 24000, clk cycles idle between frame end and next scan_start (2 ms at 12 MHz)
- FRAME_TIMEOUT_CYC, 480000, max clk cycles in WAIT_FRAME before abandoning the frame (40 ms)
- DEB_FRAMES, 3, consecutive identical frames required to accept a new key pattern (range 1..7)
- FIFO_DEPTH, 4, event FIFO entries (power of 2)
- REPEAT_FRAMES, 16, auto-repeat interval in frames (used only with KEY_REPEAT_EN)

Ports:
- clk  in  1  12 MHz system clock
- reset_n  in  1  synchronous reset, asserted high (active-high despite the name)
- enable  in  1  level; 1 = run periodic scans
- scan_start  out  1  one-cycle pulse; reader begins a frame
- frame_valid  in  1  one-cycle pulse from reader; frame_data valid this cycle
- frame_data  in  16  raw key bits, 1 = pressed, bit i = key i+1
- key_state  out  16  debounced key pattern
- nokey  out  1  key_state == 0
- ev_valid  out  1  FIFO head valid
- ev_ready  in  1  consumer accepts head when ev_valid & ev_ready
- ev_key  out  4  key index 0..15 of head event
- ev_press  out  1  1 = press, 0 = release
- ev_repeat  out  1  1 = auto-repeat event (always 0 without KEY_REPEAT_EN)
- ev_overflow  out  1  sticky; an event was dropped because the FIFO was full
- timeout_err  out  1  sticky; a frame timed out
- clear_err  in  1  clears ev_overflow and timeout_err next cycle (a set event in the same cycle wins)

Behaviour:
- Reset values (any state, mid-operation included): FSM = IDLE; scan_start 0; key_state 0; nokey 1; candidate 0; match count 0; FIFO flushed so ev_valid 0; ev_key/ev_press/ev_repeat 0; sticky flags 0; all counters 0.
- IDLE:
  - enable=1 -> START.
  - enable=0 -> stay in IDLE.
- START:
  - scan_start=1 for exactly one cycle, then -> WAIT_FRAME with the timeout counter cleared.
- WAIT_FRAME:
  - frame_valid=1 -> run the debounce update, then -> EMIT.
  - Otherwise the counter increments. At FRAME_TIMEOUT_CYC-1: set timeout_err, leave debounce state untouched, -> GAP.
  - frame_valid outside WAIT_FRAME is ignored.
  - enable dropping here does not abort; the frame completes.
- Debounce update:
  - frame_data == candidate: count saturates at DEB_FRAMES.
  - frame_data != candidate: candidate <= frame_data, count <= 1.
  - Acceptance happens when count becomes DEB_FRAMES (the edge, not the saturated hold) and candidate != key_state. Then diff <= candidate ^ key_state and key_state <= candidate in the same cycle.
  - With DEB_FRAMES=1, every differing frame is accepted immediately.
- EMIT: walks bit index 0..15, one bit per cycle (16 cycles, even when diff=0), then -> GAP.
  - For each diff[i]=1, push {key=i, press=key_state[i], repeat=0}.
  - Events are therefore ordered lowest index first.
- GAP: counts SCAN_GAP_CYC cycles, then -> START if enable=1, else -> IDLE.
- Scan period = 1 + frame time + 16 + SCAN_GAP_CYC cycles.
- FIFO behaviour:
  - Push to a non-full FIFO: ev_valid high the next cycle.
  - Push while full with no pop that cycle: event dropped, ev_overflow set.
  - Push and pop in the same cycle while full: both succeed.
  - Pop while empty: ignored.
  - Head outputs are stable while ev_valid & !ev_ready.
- Widths: timeout and gap counters are sized by $clog2 of their parameter. The match count is 3 bits.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - While exactly one bit of key_state is set and unchanged, a frame counter increments on each accepted frame_valid; it resets on any key_state change or a non-single pattern.
  - Every REPEAT_FRAMES frames, EMIT pushes {key=that index, press=1, repeat=1}.
  - Overflow rules are the same as for normal events.
- Undefined: no repeat logic is synthesized and ev_repeat is tied to 0.

Decomposition:
- Package keypad_pkg:
  - NUM_KEYS=16 and KEY_IDX_W=4.
  - FSM state encoding: IDLE, START, WAIT_FRAME, EMIT, GAP.
  - Packed event type {key[3:0], press, repeat}, 6 bits.
- One sub-module, key_event_fifo: synchronous FIFO with depth parameter, push/pop/full/empty, same-cycle push+pop when full. The controller owns the FSM, debounce and EMIT walk.

Test Plan:
- Reset mid-EMIT while the FIFO holds 2 events -> next cycle: ev_valid=0, key_state=0, FSM IDLE, scan_start=0, with no further pulse until enable is seen.
- DEB_FRAMES=3, frames 0x0001, 0x0001, 0x0001 -> after the third frame key_state=0x0001 and one event {key=0, press=1}. Then frames 0x0000 x3 -> event {key=0, press=0}.
- Glitch: frames 0x0010, 0x0000, 0x0010, 0x0010 -> key_state stays 0x0000 and no events; a fifth frame 0x0010 accepts the pattern.
- Accept 0x8003 from 0, with ev_ready=0 and FIFO_DEPTH=4 -> 3 events in order key 0, 1, 15 (all press); ev_overflow=0. Next accept 0x0000 produces 3 release events; one is pushed (FIFO now full), the remaining 2 are dropped, and ev_overflow=1 until clear_err.
- No frame_valid after scan_start -> timeout_err=1 at FRAME_TIMEOUT_CYC cycles, then after SCAN_GAP_CYC cycles a new scan_start. Also check scan_start period = frame time + 17 + SCAN_GAP_CYC.
- KEY_REPEAT_EN, REPEAT_FRAMES=4, key 5 held -> one press event, then {key=5, press=1, repeat=1} every 4 frames. Pressing a second key stops repeat events.
